pw_lock_fsm: RTL and testbench
==============================

# pw_lock_fsm

Parametrised code-entry lock for the DE10-Lite password exercises. Accepts digits from the switches on rising edges of an enter key, compares an N-digit entry against a stored code, counts failed attempts and enforces a timed lockout after MAX_TRIES failures. It sits between the board top (switches, keys, clk_divider tick) and the HEX/LEDR display decoders. Behaviour is fully synchronous to the 50 MHz clock; the slow tick is used only as an enable.

## Interface
- N_DIGITS, 4: code length in digits (≥1)
- DIGIT_W, 4: bits per digit
- MAX_TRIES, 3: failed attempts before lockout (≥1)
- LOCK_TICKS, 10: lockout duration in tick pulses (≥1)
- DEFAULT_CODE, 'h1234: reset code, N_DIGITS*DIGIT_W bits, first digit in MS digit
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle enable pulse (1 Hz from clk_divider)
- digit_in  in  DIGIT_W  digit value from switches
- key_enter  in  1  level, already synchronised; rising edge = enter
- key_clear  in  1  level, already synchronised; rising edge = clear/relock
- entry_bus  out  N_DIGITS*DIGIT_W  digits entered so far, newest in LS digit
- digits_entered  out  $clog2(N_DIGITS+1)  count of captured digits
- unlocked  out  1  high in OPEN
- fail  out  1  high in FAIL
- locked_out  out  1  high in LOCKOUT
- tries_left  out  $clog2(MAX_TRIES+1)  remaining attempts
- lock_remaining  out  $clog2(LOCK_TICKS+1)  lockout ticks remaining, 0 otherwise
- code_changed  out  1  one-cycle pulse when a new code is stored

## Operation
- Edge detect: enter_p = key_enter & ~prev_enter; same for clear_p. prev registers reset to 0.
- States: IDLE, ENTRY, CHECK, OPEN, FAIL, LOCKOUT, (REPROG if enabled).
- IDLE/ENTRY: enter_p shifts digit_in into entry_bus (entry_bus <= {entry_bus, digit_in}), digits_entered+1, state ENTRY. On the N_DIGITS-th capture go to CHECK.
- CHECK (one cycle): entry_bus == code → OPEN, tries_left ← MAX_TRIES. Mismatch → tries_left−1; if result 0 → LOCKOUT, lock_remaining ← LOCK_TICKS; else FAIL. entry_bus and digits_entered clear on leaving CHECK.
- FAIL: leaves to IDLE on next tick.
- LOCKOUT: each tick decrements lock_remaining; tick with lock_remaining==1 → IDLE, lock_remaining 0, tries_left ← MAX_TRIES. enter/clear ignored.
- OPEN: clear_p → IDLE (relock). enter_p handled per Configuration.
- clear_p in ENTRY: entry cleared, IDLE, no attempt consumed. clear_p in IDLE/FAIL/CHECK ignored.
- enter_p and clear_p same cycle: clear wins.
- Digit values are not range-checked; any DIGIT_W value is accepted.

## Timing
- Reset: state IDLE, code ← DEFAULT_CODE, entry_bus 0, digits_entered 0, tries_left MAX_TRIES, lock_remaining 0, all flags 0.
- Capture: enter_p high in cycle t → entry_bus/digits_entered updated after edge t.
- Last digit edge t → CHECK after t → OPEN/FAIL/LOCKOUT visible after t+1.
- All outputs registered or decoded from registered state; no comb path from inputs.
- rst mid-entry or mid-lockout returns fully to reset values, including code.

## Configuration
- PW_LOCK_REPROG_EN defined: in OPEN, enter_p moves to REPROG and captures that digit as first of a new code; REPROG captures digits like ENTRY; after N_DIGITS, code ← entry_bus, code_changed pulses one cycle, state IDLE. clear_p in REPROG aborts to IDLE, code unchanged.
- Undefined: no REPROG state, code is constant DEFAULT_CODE, enter_p ignored in OPEN, code_changed tied 0.

## Structure
- Package pw_lock_pkg: state enum type, state encodings, helper function for digit count width.
- Sub-module edge_rise (one register + AND), instantiated twice for enter and clear.

## Test plan
- Defaults: enter 1,2,3,4 → CHECK one cycle, then unlocked=1, tries_left=3; clear edge → IDLE, unlocked=0.
- Enter 1,2,3,5 → fail=1, tries_left=2; next tick → IDLE, entry_bus=0.
- Three wrong codes, LOCK_TICKS=5 → locked_out=1, lock_remaining=5; enter edges ignored; after 5 ticks → IDLE, tries_left=3.
- Enter 1,2 then clear → digits_entered=0, tries_left unchanged; enter+clear same cycle → no capture.
- REPROG_EN: unlock, enter 9,8,7,6 → code_changed one pulse; 1,2,3,4 now fails, 9,8,7,6 unlocks.
- rst asserted during lockout at lock_remaining=3 → all outputs at reset values next cycle, code back to 'h1234.

Source files
------------

// File: rtl/pw_lock_pkg.sv
// Shared types for the code-entry lock: state encoding and width helper.
package pw_lock_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_FAIL    = 3'd4,
    S_LOCKOUT = 3'd5,
    S_REPROG  = 3'd6
  } state_t;

  // Bits needed to hold a count from 0 to n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector on an already synchronised level.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/pw_lock_fsm.sv
// Code-entry lock with attempt counter and timed lockout.
// Define PW_LOCK_REPROG_EN to allow changing the code while open.
module pw_lock_fsm
  import pw_lock_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int DIGIT_W    = 4,
  parameter int MAX_TRIES  = 3,
  parameter int LOCK_TICKS = 10,
  parameter logic [N_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 'h1234
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic [DIGIT_W-1:0]            digit_in,
  input  logic                          key_enter,
  input  logic                          key_clear,
  output logic [N_DIGITS*DIGIT_W-1:0]   entry_bus,
  output logic [cnt_w(N_DIGITS)-1:0]    digits_entered,
  output logic                          unlocked,
  output logic                          fail,
  output logic                          locked_out,
  output logic [cnt_w(MAX_TRIES)-1:0]   tries_left,
  output logic [cnt_w(LOCK_TICKS)-1:0]  lock_remaining,
  output logic                          code_changed
);

  localparam int BUS = N_DIGITS * DIGIT_W;
  localparam int CW  = cnt_w(N_DIGITS);
  localparam int TW  = cnt_w(MAX_TRIES);
  localparam int LW  = cnt_w(LOCK_TICKS);

  state_t           state;
  logic             enter_p;
  logic             clear_p;
  logic [BUS-1:0]   code;
  logic [BUS-1:0]   cap_bus;
  logic [CW-1:0]    cap_cnt;
  logic             cap_done;

  edge_rise u_enter (
    .clk   (clk),
    .rst   (rst),
    .level (key_enter),
    .rise  (enter_p)
  );

  edge_rise u_clear (
    .clk   (clk),
    .rst   (rst),
    .level (key_clear),
    .rise  (clear_p)
  );

  // Shift form keeps this legal for a single-digit code.
  assign cap_bus  = (entry_bus << DIGIT_W) | BUS'(digit_in);
  assign cap_cnt  = digits_entered + CW'(1);
  assign cap_done = (cap_cnt == CW'(N_DIGITS));

`ifdef PW_LOCK_REPROG_EN
  logic chg;
  assign code_changed = chg;
`else
  assign code         = DEFAULT_CODE;
  assign code_changed = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      entry_bus      <= '0;
      digits_entered <= '0;
      tries_left     <= TW'(MAX_TRIES);
      lock_remaining <= '0;
`ifdef PW_LOCK_REPROG_EN
      code           <= DEFAULT_CODE;
      chg            <= 1'b0;
`endif
    end else begin
`ifdef PW_LOCK_REPROG_EN
      chg <= 1'b0;
`endif
      case (state)
        S_IDLE, S_ENTRY: begin
          if (clear_p) begin
            if (state == S_ENTRY) begin
              entry_bus      <= '0;
              digits_entered <= '0;
              state          <= S_IDLE;
            end
          end else if (enter_p) begin
            entry_bus      <= cap_bus;
            digits_entered <= cap_cnt;
            state          <= cap_done ? S_CHECK : S_ENTRY;
          end
        end
        S_CHECK: begin
          entry_bus      <= '0;
          digits_entered <= '0;
          if (entry_bus == code) begin
            tries_left <= TW'(MAX_TRIES);
            state      <= S_OPEN;
          end else begin
            tries_left <= tries_left - TW'(1);
            if (tries_left == TW'(1)) begin
              lock_remaining <= LW'(LOCK_TICKS);
              state          <= S_LOCKOUT;
            end else begin
              state <= S_FAIL;
            end
          end
        end
        S_FAIL: begin
          if (tick) state <= S_IDLE;
        end
        S_LOCKOUT: begin
          if (tick) begin
            if (lock_remaining == LW'(1)) begin
              lock_remaining <= '0;
              tries_left     <= TW'(MAX_TRIES);
              state          <= S_IDLE;
            end else begin
              lock_remaining <= lock_remaining - LW'(1);
            end
          end
        end
        S_OPEN: begin
          if (clear_p) begin
            state <= S_IDLE;
`ifdef PW_LOCK_REPROG_EN
          end else if (enter_p) begin
            if (cap_done) begin
              code  <= cap_bus;
              chg   <= 1'b1;
              state <= S_IDLE;
            end else begin
              entry_bus      <= cap_bus;
              digits_entered <= cap_cnt;
              state          <= S_REPROG;
            end
`endif
          end
        end
`ifdef PW_LOCK_REPROG_EN
        S_REPROG: begin
          if (clear_p) begin
            entry_bus      <= '0;
            digits_entered <= '0;
            state          <= S_IDLE;
          end else if (enter_p) begin
            if (cap_done) begin
              code           <= cap_bus;
              chg            <= 1'b1;
              entry_bus      <= '0;
              digits_entered <= '0;
              state          <= S_IDLE;
            end else begin
              entry_bus      <= cap_bus;
              digits_entered <= cap_cnt;
            end
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  assign unlocked   = (state == S_OPEN);
  assign fail       = (state == S_FAIL);
  assign locked_out = (state == S_LOCKOUT);

endmodule

// File: tb/tb_pw_lock_fsm.sv
// Directed bench for pw_lock_fsm (LOCK_TICKS = 5).
// Stimulus changes and sampling both happen on the falling edge.
module tb_pw_lock_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [3:0]  digit_in;
  logic        key_enter;
  logic        key_clear;
  logic [15:0] entry_bus;
  logic [2:0]  digits_entered;
  logic        unlocked;
  logic        fail;
  logic        locked_out;
  logic [1:0]  tries_left;
  logic [2:0]  lock_remaining;
  logic        code_changed;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pw_lock_fsm #(
    .N_DIGITS     (4),
    .DIGIT_W      (4),
    .MAX_TRIES    (3),
    .LOCK_TICKS   (5),
    .DEFAULT_CODE (16'h1234)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .tick           (tick),
    .digit_in       (digit_in),
    .key_enter      (key_enter),
    .key_clear      (key_clear),
    .entry_bus      (entry_bus),
    .digits_entered (digits_entered),
    .unlocked       (unlocked),
    .fail           (fail),
    .locked_out     (locked_out),
    .tries_left     (tries_left),
    .lock_remaining (lock_remaining),
    .code_changed   (code_changed)
  );

  task automatic press(input logic [3:0] d);
    @(negedge clk);
    digit_in  = d;
    key_enter = 1'b1;
    @(negedge clk);
    key_enter = 1'b0;
  endtask

  task automatic press_clear();
    @(negedge clk);
    key_clear = 1'b1;
    @(negedge clk);
    key_clear = 1'b0;
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  // Enters four digits, then steps past the CHECK cycle.
  task automatic enter_code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b0; digit_in = '0;
    key_enter = 1'b0; key_clear = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({entry_bus, digits_entered} !== 19'd0) begin
      errors++;
      $display("FAIL reset_entry: got %h/%0d want 0/0",
               entry_bus, digits_entered);
    end
    checks++;
    if ({unlocked, fail, locked_out, code_changed} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000",
               {unlocked, fail, locked_out, code_changed});
    end
    checks++;
    if (tries_left !== 2'd3 || lock_remaining !== 3'd0) begin
      errors++;
      $display("FAIL reset_counts: got %0d/%0d want 3/0",
               tries_left, lock_remaining);
    end
  endtask

  task automatic test_unlock();
    press(4'h1);
    press(4'h2);
    checks++;
    if (entry_bus !== 16'h0012 || digits_entered !== 3'd2) begin
      errors++;
      $display("FAIL capture: got %h/%0d want 0012/2",
               entry_bus, digits_entered);
    end
    press(4'h3);
    press(4'h4);
    checks++;
    if (unlocked !== 1'b0 || entry_bus !== 16'h1234
        || digits_entered !== 3'd4) begin
      errors++;
      $display("FAIL check_cycle: got u=%0d %h/%0d want 0 1234/4",
               unlocked, entry_bus, digits_entered);
    end
    @(negedge clk);
    checks++;
    if (unlocked !== 1'b1 || tries_left !== 2'd3
        || entry_bus !== 16'h0) begin
      errors++;
      $display("FAIL open: got u=%0d t=%0d e=%h want 1 3 0000",
               unlocked, tries_left, entry_bus);
    end
`ifndef PW_LOCK_REPROG_EN
    press(4'h7);
    checks++;
    if (unlocked !== 1'b1 || digits_entered !== 3'd0) begin
      errors++;
      $display("FAIL open_enter_ignored: got u=%0d d=%0d want 1 0",
               unlocked, digits_entered);
    end
`endif
    press_clear();
    checks++;
    if (unlocked !== 1'b0) begin
      errors++;
      $display("FAIL relock: got %0d want 0", unlocked);
    end
  endtask

  task automatic test_fail();
    enter_code(16'h1235);
    checks++;
    if (fail !== 1'b1 || tries_left !== 2'd2
        || entry_bus !== 16'h0) begin
      errors++;
      $display("FAIL wrong_code: got f=%0d t=%0d e=%h want 1 2 0000",
               fail, tries_left, entry_bus);
    end
    pulse_tick();
    checks++;
    if (fail !== 1'b0 || tries_left !== 2'd2
        || entry_bus !== 16'h0) begin
      errors++;
      $display("FAIL fail_exit: got f=%0d t=%0d e=%h want 0 2 0000",
               fail, tries_left, entry_bus);
    end
  endtask

  task automatic test_lockout();
    enter_code(16'h0000);
    checks++;
    if (fail !== 1'b1 || tries_left !== 2'd1) begin
      errors++;
      $display("FAIL second_wrong: got f=%0d t=%0d want 1 1",
               fail, tries_left);
    end
    pulse_tick();
    enter_code(16'h4321);
    checks++;
    if (locked_out !== 1'b1 || lock_remaining !== 3'd5
        || tries_left !== 2'd0 || fail !== 1'b0) begin
      errors++;
      $display("FAIL lockout_entry: got l=%0d r=%0d t=%0d f=%0d want 1 5 0 0",
               locked_out, lock_remaining, tries_left, fail);
    end
    press(4'h1);
    press_clear();
    checks++;
    if (locked_out !== 1'b1 || digits_entered !== 3'd0
        || lock_remaining !== 3'd5) begin
      errors++;
      $display("FAIL lockout_keys: got l=%0d d=%0d r=%0d want 1 0 5",
               locked_out, digits_entered, lock_remaining);
    end
    repeat (4) pulse_tick();
    checks++;
    if (locked_out !== 1'b1 || lock_remaining !== 3'd1) begin
      errors++;
      $display("FAIL lockout_count: got l=%0d r=%0d want 1 1",
               locked_out, lock_remaining);
    end
    pulse_tick();
    checks++;
    if (locked_out !== 1'b0 || lock_remaining !== 3'd0
        || tries_left !== 2'd3) begin
      errors++;
      $display("FAIL lockout_exit: got l=%0d r=%0d t=%0d want 0 0 3",
               locked_out, lock_remaining, tries_left);
    end
  endtask

  task automatic test_clear();
    press(4'h1);
    press(4'h2);
    press_clear();
    checks++;
    if (digits_entered !== 3'd0 || entry_bus !== 16'h0
        || tries_left !== 2'd3) begin
      errors++;
      $display("FAIL clear_entry: got d=%0d e=%h t=%0d want 0 0000 3",
               digits_entered, entry_bus, tries_left);
    end
    @(negedge clk);
    digit_in  = 4'h7;
    key_enter = 1'b1;
    key_clear = 1'b1;
    @(negedge clk);
    key_enter = 1'b0;
    key_clear = 1'b0;
    checks++;
    if (digits_entered !== 3'd0 || entry_bus !== 16'h0) begin
      errors++;
      $display("FAIL clear_wins: got d=%0d e=%h want 0 0000",
               digits_entered, entry_bus);
    end
    enter_code(16'h1234);
    checks++;
    if (unlocked !== 1'b1) begin
      errors++;
      $display("FAIL unlock_after_clear: got %0d want 1", unlocked);
    end
    press_clear();
  endtask

`ifdef PW_LOCK_REPROG_EN
  task automatic test_reprog();
    enter_code(16'h1234);
    press(4'h9);
    press(4'h8);
    press(4'h7);
    press(4'h6);
    checks++;
    if (code_changed !== 1'b1 || unlocked !== 1'b0) begin
      errors++;
      $display("FAIL reprog_pulse: got c=%0d u=%0d want 1 0",
               code_changed, unlocked);
    end
    @(negedge clk);
    checks++;
    if (code_changed !== 1'b0) begin
      errors++;
      $display("FAIL reprog_pulse_len: got %0d want 0", code_changed);
    end
    enter_code(16'h1234);
    checks++;
    if (fail !== 1'b1) begin
      errors++;
      $display("FAIL old_code_rejected: got %0d want 1", fail);
    end
    pulse_tick();
    enter_code(16'h9876);
    checks++;
    if (unlocked !== 1'b1 || tries_left !== 2'd3) begin
      errors++;
      $display("FAIL new_code_accepted: got u=%0d t=%0d want 1 3",
               unlocked, tries_left);
    end
    press_clear();
  endtask
`endif

  task automatic test_rst_lockout();
    enter_code(16'h1111);
    pulse_tick();
    enter_code(16'h2222);
    pulse_tick();
    enter_code(16'h3333);
    repeat (2) pulse_tick();
    checks++;
    if (locked_out !== 1'b1 || lock_remaining !== 3'd3) begin
      errors++;
      $display("FAIL pre_rst: got l=%0d r=%0d want 1 3",
               locked_out, lock_remaining);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({locked_out, unlocked, fail, code_changed} !== 4'b0
        || lock_remaining !== 3'd0 || tries_left !== 2'd3
        || entry_bus !== 16'h0 || digits_entered !== 3'd0) begin
      errors++;
      $display("FAIL rst_lockout: got l=%0d r=%0d t=%0d e=%h want 0 0 3 0000",
               locked_out, lock_remaining, tries_left, entry_bus);
    end
    rst = 1'b0;
    enter_code(16'h1234);
    checks++;
    if (unlocked !== 1'b1) begin
      errors++;
      $display("FAIL rst_code: got %0d want 1", unlocked);
    end
    press_clear();
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_fail();
    test_lockout();
    test_clear();
`ifdef PW_LOCK_REPROG_EN
    test_reprog();
`endif
    test_rst_lockout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
